// File: rtl/alu_result_retire.sv
// Retire stage for ALU results: registers write-back and branch strobes, squashes the
// wrong path after a taken branch, counts retired instructions and flags illegal opcodes.
module alu_result_retire #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RD_W         = 7,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic [4:0]        in_opcode,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [RD_W-1:0]   in_branch,
    input  logic [DATA_W-1:0] in_result,
    output logic              wb_we,
    output logic [RD_W-1:0]   wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              br_taken,
    output logic [RD_W-1:0]   br_target,
    output logic              squash_active,
    output logic              bad_op_err,
    output logic [4:0]        bad_op_code,
    output logic [31:0]       retired_count
);

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

    logic              wb_we_q, wb_we_d;
    logic [RD_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              br_taken_q, br_taken_d;
    logic [RD_W-1:0]   br_target_q, br_target_d;
    logic [3:0]        squash_cnt_q, squash_cnt_d;
    logic              squash_active_q, squash_active_d;
    logic              bad_op_err_q, bad_op_err_d;
    logic [4:0]        bad_op_code_q, bad_op_code_d;
    logic [31:0]       retired_count_q, retired_count_d;

    logic accept;
    logic retire;

    assign accept = in_valid & ~stall;

    always_comb begin
        wb_we_d         = 1'b0;
        wb_addr_d       = wb_addr_q;
        wb_data_d       = wb_data_q;
        br_taken_d      = 1'b0;
        br_target_d     = br_target_q;
        squash_cnt_d    = squash_cnt_q;
        bad_op_err_d    = bad_op_err_q;
        bad_op_code_d   = bad_op_code_q;
        retired_count_d = retired_count_q;
        retire          = 1'b0;

        if (accept) begin
            if (squash_cnt_q != 4'd0) begin
                // Wrong-path slot: consume it, nothing else happens (a branch here never reloads).
                squash_cnt_d = squash_cnt_q - 4'd1;
            end else begin
                case (in_opcode)
                    5'd0: retire = 1'b1;
                    5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10: begin
                        wb_addr_d = in_rd;
                        wb_data_d = in_result;
                        wb_we_d   = |in_rd;
                        retire    = 1'b1;
                    end
                    5'd7: begin
                        br_taken_d  = 1'b1;
                        br_target_d = in_branch;
                        retire      = 1'b1;
                    end
                    5'd8: begin
                        br_taken_d  = in_result[0];
                        br_target_d = in_branch;
                        retire      = 1'b1;
                    end
                    default: begin
                        bad_op_err_d = 1'b1;
                        if (!bad_op_err_q) begin
                            bad_op_code_d = in_opcode;
                        end
                    end
                endcase
                if (retire) begin
                    retired_count_d = retired_count_q + 32'd1;
                end
                if (br_taken_d) begin
                    squash_cnt_d = FlushLoad;
                end
            end
        end

        squash_active_d = (squash_cnt_d != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we_q         <= 1'b0;
            wb_addr_q       <= '0;
            wb_data_q       <= '0;
            br_taken_q      <= 1'b0;
            br_target_q     <= '0;
            squash_cnt_q    <= 4'd0;
            squash_active_q <= 1'b0;
            bad_op_err_q    <= 1'b0;
            bad_op_code_q   <= 5'd0;
            retired_count_q <= 32'd0;
        end else begin
            wb_we_q         <= wb_we_d;
            wb_addr_q       <= wb_addr_d;
            wb_data_q       <= wb_data_d;
            br_taken_q      <= br_taken_d;
            br_target_q     <= br_target_d;
            squash_cnt_q    <= squash_cnt_d;
            squash_active_q <= squash_active_d;
            bad_op_err_q    <= bad_op_err_d;
            bad_op_code_q   <= bad_op_code_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign wb_we         = wb_we_q;
    assign wb_addr       = wb_addr_q;
    assign wb_data       = wb_data_q;
    assign br_taken      = br_taken_q;
    assign br_target     = br_target_q;
    assign squash_active = squash_active_q;
    assign bad_op_err    = bad_op_err_q;
    assign bad_op_code   = bad_op_code_q;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_alu_result_retire.sv
// Bench for alu_result_retire: directed vectors, a rule-level reference model compared every
// cycle, and literal expectations at the points of interest.
module tb_alu_result_retire;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 7;
    localparam int unsigned FLUSH  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              stall = 1'b0;
    logic [4:0]        in_opcode = '0;
    logic [RD_W-1:0]   in_rd = '0;
    logic [RD_W-1:0]   in_branch = '0;
    logic [DATA_W-1:0] in_result = '0;
    logic              wb_we;
    logic [RD_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              br_taken;
    logic [RD_W-1:0]   br_target;
    logic              squash_active;
    logic              bad_op_err;
    logic [4:0]        bad_op_code;
    logic [31:0]       retired_count;

    alu_result_retire #(
        .DATA_W      (DATA_W),
        .RD_W        (RD_W),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .stall        (stall),
        .in_opcode    (in_opcode),
        .in_rd        (in_rd),
        .in_branch    (in_branch),
        .in_result    (in_result),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .squash_active(squash_active),
        .bad_op_err   (bad_op_err),
        .bad_op_code  (bad_op_code),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: what the outputs must be after each edge.
    logic              m_we, m_bt, m_err;
    logic [RD_W-1:0]   m_addr, m_tgt;
    logic [DATA_W-1:0] m_data;
    logic [4:0]        m_code;
    logic [31:0]       m_count;
    int                m_pending;  // wrong-path instructions still to be discarded
    logic              chk_en = 1'b0;
    logic              preload = 1'b0;

    always @(posedge clk) begin
        if (preload) m_count = 32'hFFFF_FFFF;
        if (rst) begin
            m_we = 0; m_bt = 0; m_err = 0; m_addr = 0; m_tgt = 0;
            m_data = 0; m_code = 0; m_count = 0; m_pending = 0;
        end else begin
            m_we = 0;
            m_bt = 0;
            if (in_valid && !stall) begin
                if (m_pending > 0) begin
                    m_pending = m_pending - 1;
                end else if (in_opcode == 0) begin
                    m_count = m_count + 1;
                end else if (in_opcode inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10}) begin
                    m_addr  = in_rd;
                    m_data  = in_result;
                    m_we    = (in_rd != 0);
                    m_count = m_count + 1;
                end else if (in_opcode == 7 || in_opcode == 8) begin
                    m_bt    = (in_opcode == 7) ? 1'b1 : in_result[0];
                    m_tgt   = in_branch;
                    m_count = m_count + 1;
                    if (m_bt) m_pending = FLUSH;
                end else begin
                    if (!m_err) m_code = in_opcode;
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_wb_we", 64'(wb_we), 64'(m_we));
            check("cyc_wb_addr", 64'(wb_addr), 64'(m_addr));
            check("cyc_wb_data", 64'(wb_data), 64'(m_data));
            check("cyc_br_taken", 64'(br_taken), 64'(m_bt));
            check("cyc_br_target", 64'(br_target), 64'(m_tgt));
            check("cyc_squash_active", 64'(squash_active), 64'(m_pending != 0));
            check("cyc_bad_op_err", 64'(bad_op_err), 64'(m_err));
            check("cyc_bad_op_code", 64'(bad_op_code), 64'(m_code));
            check("cyc_retired_count", 64'(retired_count), 64'(m_count));
        end
    end

    // Present one input set, let one edge sample it; returns 1 time unit after that edge.
    task automatic cycle(input logic v, input logic s, input logic [4:0] op,
                         input logic [RD_W-1:0] rd, input logic [RD_W-1:0] br,
                         input logic [DATA_W-1:0] res);
        in_valid = v; stall = s; in_opcode = op; in_rd = rd; in_branch = br; in_result = res;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_outputs_zero"},
              64'({wb_we, br_taken, squash_active, bad_op_err}), 64'd0);
        check({tag, "_fields_zero"},
              64'(wb_addr) | 64'(wb_data) | 64'(br_target) | 64'(bad_op_code) | 64'(retired_count),
              64'd0);
    endtask

    initial begin
        #2;
        idle();
        idle();
        chk_en = 1'b1;
        all_zero("reset");
        rst = 1'b0;

        // Basic write
        cycle(1, 0, 5'd5, 7'd3, 7'd0, 32'h0000_002A);
        check("wr_we", 64'(wb_we), 64'd1);
        check("wr_addr", 64'(wb_addr), 64'd3);
        check("wr_data", 64'(wb_data), 64'h2A);
        check("wr_count", 64'(retired_count), 64'd1);
        idle();
        check("wr_idle_we", 64'(wb_we), 64'd0);
        check("wr_idle_addr_hold", 64'(wb_addr), 64'd3);

        // Taken branch squashes the next two accepted instructions
        do_reset();
        cycle(1, 0, 5'd7, 7'd0, 7'h12, 32'd0);
        check("b_taken", 64'(br_taken), 64'd1);
        check("b_target", 64'(br_target), 64'h12);
        check("b_squash_on", 64'(squash_active), 64'd1);
        cycle(1, 1, 5'd5, 7'd4, 7'd0, 32'd11);  // stall mid-squash: counter holds
        check("b_stall_hold", 64'(squash_active), 64'd1);
        cycle(1, 0, 5'd5, 7'd4, 7'd0, 32'd11);
        check("b_sq1_we", 64'(wb_we), 64'd0);
        check("b_sq1_active", 64'(squash_active), 64'd1);
        cycle(1, 0, 5'd2, 7'd5, 7'd0, 32'd22);
        check("b_sq2_we", 64'(wb_we), 64'd0);
        check("b_sq2_active", 64'(squash_active), 64'd0);
        cycle(1, 0, 5'd5, 7'd6, 7'd0, 32'd33);
        check("b_after_we", 64'(wb_we), 64'd1);
        check("b_after_addr", 64'(wb_addr), 64'd6);
        check("b_after_count", 64'(retired_count), 64'd2);

        // Conditional branch
        cycle(1, 0, 5'd8, 7'd0, 7'h09, 32'd0);
        check("beg0_taken", 64'(br_taken), 64'd0);
        check("beg0_squash", 64'(squash_active), 64'd0);
        cycle(1, 0, 5'd8, 7'd0, 7'h05, 32'd1);
        check("beg1_taken", 64'(br_taken), 64'd1);
        check("beg1_target", 64'(br_target), 64'h05);
        cycle(1, 0, 5'd0, 7'd0, 7'd0, 32'd0);
        cycle(1, 0, 5'd8, 7'd0, 7'h33, 32'd1);  // squashed branch must not reload
        check("sq_branch_no_strobe", 64'(br_taken), 64'd0);
        check("sq_branch_no_reload", 64'(squash_active), 64'd0);
        check("beg_count", 64'(retired_count), 64'd4);

        // Illegal opcodes
        cycle(1, 0, 5'd14, 7'd9, 7'd0, 32'd7);
        cycle(1, 0, 5'd20, 7'd9, 7'd0, 32'd7);
        check("ill_err", 64'(bad_op_err), 64'd1);
        check("ill_code_first", 64'(bad_op_code), 64'd14);
        check("ill_count", 64'(retired_count), 64'd4);
        check("ill_no_we", 64'(wb_we), 64'd0);

        // Stall holds the instruction until released
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 5'd1, 7'd7, 7'd0, 32'h55);
            check("stall_no_we", 64'(wb_we), 64'd0);
        end
        check("stall_count", 64'(retired_count), 64'd4);
        cycle(1, 0, 5'd1, 7'd7, 7'd0, 32'h55);
        check("unstall_we", 64'(wb_we), 64'd1);
        idle();
        check("unstall_once", 64'(retired_count), 64'd5);

        // Register 0 write suppressed but retires
        cycle(1, 0, 5'd9, 7'd0, 7'd0, 32'hDEAD);
        check("rd0_no_we", 64'(wb_we), 64'd0);
        check("rd0_count", 64'(retired_count), 64'd6);

        // Counter wrap via preload
        chk_en = 1'b0;
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        preload = 1'b1;
        cycle(1, 0, 5'd0, 7'd0, 7'd0, 32'd0);
        preload = 1'b0;
        chk_en = 1'b1;
        check("wrap_count", 64'(retired_count), 64'd0);

        // Reset during squash
        cycle(1, 0, 5'd7, 7'd0, 7'h2C, 32'd0);
        cycle(1, 0, 5'd5, 7'd8, 7'd0, 32'd1);
        check("pre_rst_squash", 64'(squash_active), 64'd1);
        rst = 1'b1;
        cycle(1, 0, 5'd5, 7'd8, 7'd0, 32'd1);
        rst = 1'b0;
        all_zero("rst_squash");
        idle();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_result_retire.md
Name: alu_result_retire

Overview:
- Consumer end of the ALU result interface: accepts {opcode, destination, branch target, result} from the combinational ALU and retires it in one registered stage.
- Produces register-file write strobes and branch redirects.
- Squashes wrong-path instructions after a taken branch.
- Keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- DATA_W, 32, width of ALU result and write data
- RD_W, 7, width of destination register and branch target fields
- FLUSH_CYCLES, 2, wrong-path instructions squashed after a taken branch (0..15; 0 disables squash)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  ALU output fields valid this cycle
- stall  in  1  downstream hold; no input accepted while high
- in_opcode  in  5  opcode forwarded by ALU
- in_rd  in  RD_W  destination register (ALU RdOut)
- in_branch  in  RD_W  branch target (ALU branchResult)
- in_result  in  DATA_W  ALU result
- wb_we  out  1  register-file write strobe, one cycle per write
- wb_addr  out  RD_W  write address
- wb_data  out  DATA_W  write data
- br_taken  out  1  branch redirect strobe, one cycle
- br_target  out  RD_W  redirect target
- squash_active  out  1  squash counter nonzero
- bad_op_err  out  1  sticky illegal-opcode flag
- bad_op_code  out  5  opcode of first illegal instruction
- retired_count  out  32  retired-instruction count

Behaviour:
- Reset (rst high at clock edge): all outputs 0; squash counter 0. Reset wins over every other event, including mid-squash and mid-stall.
- Accept: the input is accepted at a rising edge when in_valid=1 and stall=0. All effects appear on the registered outputs one cycle later.
- Strobes: wb_we and br_taken are 0 in any cycle following a non-accepting edge. wb_addr, wb_data and br_target hold their previous values.
- Squash: if the squash counter is nonzero at an accepting edge, the instruction is squashed.
  - No write, branch, count or error results from it.
  - The counter decrements by 1.
  - A branch that is squashed does not reload the counter.
- Non-squashed accepted instruction, decoded by opcode:
  - 0 NOP: retires only.
  - 1,2,3,4,5,6,9,10 (register-writing ops): wb_addr=in_rd, wb_data=in_result. wb_we=1 unless in_rd==0; writes to register 0 are suppressed but still retire.
  - 7 B: br_taken=1, br_target=in_branch.
  - 8 BEG: br_taken=in_result[0], br_target=in_branch.
  - 11..31 illegal: no write, no branch, not counted.
    - bad_op_err is set and stays high until reset.
    - bad_op_code is captured only when bad_op_err was previously 0.
- Taken branch: at the same edge that sets br_taken=1, the squash counter loads FLUSH_CYCLES.
- Retire counter: retired_count increments by 1 per non-squashed legal instruction and wraps from 0xFFFFFFFF to 0.
- squash_active is registered and equals (counter != 0) after each edge.
- Stall while squashing: the counter holds; only accepted inputs decrement it.

Test Plan:
- After reset, accept opcode 5, rd=3, result=0x0000002A → next cycle wb_we=1, wb_addr=3, wb_data=0x2A; retired_count=1; following idle cycle wb_we=0.
- Accept opcode 7, branch=0x12 (FLUSH_CYCLES=2), then opcode 5 rd=4, opcode 2 rd=5, then opcode 5 rd=6:
  - br_taken=1 with target 0x12;
  - the next two instructions produce no writes, with squash_active high during them;
  - rd=6 writes; retired_count=2.
- Opcode 8 with result=0 → br_taken=0 and no squash; opcode 8 with result=1, branch=0x05 → br_taken=1, target 0x05.
- Opcode 14, then opcode 20 → bad_op_err=1, bad_op_code=14 (not 20); retired_count unchanged; no wb_we.
- Hold stall=1 with in_valid=1 for 3 cycles → no strobes, counter unchanged; release → the instruction retires exactly once.
- Preload the counter to 0xFFFFFFFF via 2^32-1 NOPs (or force), retire one more → 0. Assert rst during squash → squash_active=0 and all outputs 0 next cycle.
